ysyx_24110006_alu_stage: RTL and testbench

- Parametrised execute-stage ALU. It decodes RV32I/RV64I opcode and funct fields into operand selection, computes the result, and registers it behind valid/ready handshakes.
- Sits between IDU and LSU/WBU.
- Adds two things a purely combinational operand decoder does not have:
  - an output register with backpressure;
  - an optional multi-cycle iterative shifter, which trades area for latency.

---
 rtl/ysyx_24110006_alu_stage.sv | 207 ++++++++++++++++++++
 tb/tb_ysyx_24110006_alu_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_alu_stage.sv
// Execute-stage ALU: decodes RV32I/RV64I opcode/funct into operands, computes
// the result and holds it in an output register behind a valid/ready pair.
// Shifts longer than SHIFT_STEP are finished over several cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no operation held, ready to accept
// S_SHIFT | iterative shift in progress, not ready
// S_DONE  | result held on o_result until downstream takes it
module ysyx_24110006_alu_stage #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [6:0]      i_op,
   input  logic [2:0]      i_func,
   input  logic            i_f7b5,
   input  logic [XLEN-1:0] i_src1,
   input  logic [XLEN-1:0] i_src2,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_csr_rdata,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_br_taken,
   output logic            o_illegal
);

   localparam int SW  = $clog2(XLEN);
   localparam int SWP = SW + 1;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t            state, state_nxt;
   logic              accept;
   logic [XLEN-1:0]   op_a, op_b, sum, diff;
   logic              carry, zero, lt_s, lt_u;
   logic [XLEN-1:0]   res_c, res_final;
   logic              br_c, ill_c;
   logic              is_shift, sh_right, sh_arith;
   logic [SW-1:0]     shamt, first_amt, first_rem;
   logic [XLEN-1:0]   first_val;
   logic              multi;
   logic [XLEN-1:0]   sh_val, step_val;
   logic [SW-1:0]     sh_rem, step_amt;
   logic              sh_right_q, sh_arith_q, last;

   // Distance for one step: whatever is left, capped at SHIFT_STEP.
   function automatic logic [SW-1:0] step_of(input logic [SW-1:0] rem);
      if ({1'b0, rem} > SWP'(SHIFT_STEP)) return SW'(SHIFT_STEP);
      else return rem;
   endfunction

   function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                                input logic [SW-1:0]   amt,
                                                input logic            right,
                                                input logic            arith);
      if (!right)     return v << amt;
      else if (arith) return $signed(v) >>> amt;
      else            return v >> amt;
   endfunction

   assign accept = i_valid && o_ready;

   // Single adder/subtractor; the carry out of A + ~B + 1 gives unsigned compare.
   assign sum          = op_a + op_b;
   assign {carry, diff} = {1'b0, op_a} + {1'b0, ~op_b} + {{XLEN{1'b0}}, 1'b1};
   assign zero         = (diff == '0);
   assign lt_u         = ~carry;
   assign lt_s         = (op_a[XLEN-1] != op_b[XLEN-1]) ? op_a[XLEN-1] : diff[XLEN-1];

   // Operand selection from the opcode.
   always_comb begin
      op_a = i_src1;
      op_b = i_src2;
      case (i_op)
         OPC_LUI:                         begin op_a = '0;   op_b = i_imm;     end
         OPC_AUIPC:                       begin op_a = i_pc; op_b = i_imm;     end
         OPC_JAL, OPC_JALR:               begin op_a = i_pc; op_b = XLEN'(4);  end
         OPC_LOAD, OPC_STORE, OPC_OPIMM:  op_b = i_imm;
         default: ;
      endcase
   end

   // Result, branch and illegal decode. Only instr[30] of funct7 reaches this
   // stage, so the funct7 legality check is limited to what that bit can show.
   always_comb begin
      res_c    = '0;
      br_c     = 1'b0;
      ill_c    = 1'b0;
      is_shift = 1'b0;
      sh_right = 1'b0;
      sh_arith = 1'b0;
      shamt    = (i_op == OPC_OP) ? i_src2[SW-1:0] : i_imm[SW-1:0];
      case (i_op)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: res_c = sum;
         OPC_OPIMM, OPC_OP: begin
            case (i_func)
               3'b000: res_c = (i_op == OPC_OP && i_f7b5) ? diff : sum;
               3'b001: is_shift = 1'b1;
               3'b010: res_c = {{(XLEN-1){1'b0}}, lt_s};
               3'b011: res_c = {{(XLEN-1){1'b0}}, lt_u};
               3'b100: res_c = op_a ^ op_b;
               3'b101: begin is_shift = 1'b1; sh_right = 1'b1; sh_arith = i_f7b5; end
               3'b110: res_c = op_a | op_b;
               default: res_c = op_a & op_b;
            endcase
         end
         OPC_BRANCH: begin
            case (i_func)
               3'b000:  br_c = zero;
               3'b001:  br_c = ~zero;
               3'b100:  br_c = lt_s;
               3'b101:  br_c = ~lt_s;
               3'b110:  br_c = lt_u;
               3'b111:  br_c = ~lt_u;
               default: ill_c = 1'b1;
            endcase
         end
         OPC_SYSTEM: begin
            case (i_func)
               3'b001:  res_c = i_src1;
               3'b010:  res_c = i_src1 | i_csr_rdata;
               default: res_c = '0;
            endcase
         end
         OPC_MISCMEM: res_c = '0;
         default:     ill_c = 1'b1;
      endcase
   end

   // First shift step happens on the accept edge so short shifts cost one cycle.
   assign first_amt = step_of(shamt);
   assign first_rem = shamt - first_amt;
   assign first_val = shift_by(op_a, first_amt, sh_right, sh_arith);
   assign multi     = is_shift && (first_rem != '0);
   assign res_final = is_shift ? first_val : res_c;

   assign step_amt = step_of(sh_rem);
   assign step_val = shift_by(sh_val, step_amt, sh_right_q, sh_arith_q);
   assign last     = (sh_rem == step_amt);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = multi ? S_SHIFT : S_DONE;
         S_SHIFT: if (last)   state_nxt = S_DONE;
         S_DONE:  if (i_ready) state_nxt = accept ? (multi ? S_SHIFT : S_DONE) : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs.
   always_comb begin
      o_ready = (state == S_IDLE) || (state == S_DONE && i_ready);
      o_valid = (state == S_DONE);
   end

   // Output register and iterative shifter datapath.
   always_ff @(posedge clock) begin
      if (reset) begin
         o_result   <= '0;
         o_br_taken <= 1'b0;
         o_illegal  <= 1'b0;
         sh_val     <= '0;
         sh_rem     <= '0;
         sh_right_q <= 1'b0;
         sh_arith_q <= 1'b0;
      end else if (accept) begin
         if (!multi) o_result <= res_final;
         o_br_taken <= br_c;
         o_illegal  <= ill_c;
         sh_val     <= first_val;
         sh_rem     <= first_rem;
         sh_right_q <= sh_right;
         sh_arith_q <= sh_arith;
      end else if (state == S_SHIFT) begin
         sh_val <= step_val;
         sh_rem <= sh_rem - step_amt;
         if (last) o_result <= step_val;
      end
   end

endmodule

// File: tb/tb_ysyx_24110006_alu_stage.sv
// Bench for ysyx_24110006_alu_stage (XLEN=32, SHIFT_STEP=4): directed cases,
// randomised OP/OP-IMM against a reference model, backpressure and reset abort.
module tb_ysyx_24110006_alu_stage;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_valid, o_ready, o_valid, i_ready;
   logic [6:0]  i_op;
   logic [2:0]  i_func;
   logic        i_f7b5;
   logic [31:0] i_src1, i_src2, i_imm, i_pc, i_csr_rdata, o_result;
   logic        o_br_taken, o_illegal;

   typedef struct {
      logic [31:0] res;
      logic        br;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   ysyx_24110006_alu_stage #(.XLEN(32), .SHIFT_STEP(4)) dut (
      .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_func(i_func), .i_f7b5(i_f7b5), .i_src1(i_src1),
      .i_src2(i_src2), .i_imm(i_imm), .i_pc(i_pc), .i_csr_rdata(i_csr_rdata),
      .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
      .o_br_taken(o_br_taken), .o_illegal(o_illegal)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard monitor: one result leaves per DONE cycle with i_ready high.
   always @(negedge clock) begin : mon
      exp_t e;
      if (!reset && o_valid && i_ready) begin
         chk("sb_pending", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", 64'(o_result), 64'(e.res));
            chk("br_taken", 64'(o_br_taken), 64'(e.br));
            chk("illegal", 64'(o_illegal), 64'(e.ill));
         end
      end
   end

   function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [2:0] fn,
                                           input logic f7, input logic [31:0] a,
                                           input logic [31:0] s2, input logic [31:0] imm);
      logic [31:0] b;
      logic [4:0]  sh;
      b  = (op == OPC_OP) ? s2 : imm;
      sh = b[4:0];
      case (fn)
         3'd0:    return (op == OPC_OP && f7) ? a - b : a + b;
         3'd1:    return a << sh;
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return f7 ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic drive(input logic [6:0] op, input logic [2:0] fn, input logic f7,
                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [31:0] csr, input logic rdy);
      i_valid = 1'b1; i_op = op; i_func = fn; i_f7b5 = f7;
      i_src1 = s1; i_src2 = s2; i_imm = imm; i_pc = pc; i_csr_rdata = csr; i_ready = rdy;
   endtask

   // Waits for acceptance; returns just after the accepting edge.
   task automatic wait_accept(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         if (o_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout", 64'(o_ready), 64'd1);
   endtask

   task automatic send(input logic [6:0] op, input logic [2:0] fn, input logic f7,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [31:0] csr, input logic rdy,
                       input logic [31:0] eres, input logic ebr, input logic eill, input int elat);
      bit   ok;
      exp_t e;
      int   n;
      @(posedge clock); #1;
      drive(op, fn, f7, s1, s2, imm, pc, csr, rdy);
      wait_accept(ok);
      if (ok) begin
         e.res = eres; e.br = ebr; e.ill = eill;
         sb.push_back(e);
      end
      @(posedge clock); #1;
      i_valid = 1'b0;
      if (!ok) return;
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         n = c;
         if (o_valid) break;
         chk("busy_not_ready", 64'(o_ready), 64'd0);
      end
      chk("latency", 64'(n), 64'(elat));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit          ok;
      logic [6:0]  op;
      logic [2:0]  fn;
      logic        f7;
      logic [31:0] s1, s2, imm, b;
      int          lat;

      reset = 1'b1;
      i_valid = 1'b0; i_ready = 1'b1; i_op = '0; i_func = '0; i_f7b5 = 1'b0;
      i_src1 = '0; i_src2 = '0; i_imm = '0; i_pc = '0; i_csr_rdata = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_result", 64'(o_result), 64'd0);
      chk("rst_br", 64'(o_br_taken), 64'd0);
      chk("rst_illegal", 64'(o_illegal), 64'd0);
      chk("rst_ready", 64'(o_ready), 64'd1);
      @(posedge clock); #1;
      reset = 1'b0;

      // Directed arithmetic, compare, branch and misc cases.
      send(OPC_OP, 3'b000, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1);
      send(OPC_OP, 3'b000, 1'b1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
      send(OPC_OP, 3'b011, 1'b0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0, 1);
      send(OPC_OP, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0, 1);
      send(OPC_OP, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1);
      send(OPC_BRANCH, 3'b100, 1'b0, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1);
      send(OPC_BRANCH, 3'b111, 1'b0, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1);
      send(OPC_BRANCH, 3'b101, 1'b0, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1);
      send(OPC_BRANCH, 3'b000, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1);
      send(OPC_BRANCH, 3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1);
      send(OPC_LUI, 3'b000, 1'b0, 32'hDEAD, 32'd0, 32'h12345000, 32'h40, 32'd0, 1'b1, 32'h12345000, 1'b0, 1'b0, 1);
      send(OPC_AUIPC, 3'b000, 1'b0, 32'd0, 32'd0, 32'h20, 32'h1000, 32'd0, 1'b1, 32'h1020, 1'b0, 1'b0, 1);
      send(OPC_SYSTEM, 3'b010, 1'b0, 32'hF0, 32'd0, 32'd0, 32'd0, 32'h0F, 1'b1, 32'hFF, 1'b0, 1'b0, 1);
      send(OPC_SYSTEM, 3'b001, 1'b0, 32'hA5A5, 32'd0, 32'd0, 32'd0, 32'h0F, 1'b1, 32'hA5A5, 1'b0, 1'b0, 1);
      send(OPC_MISCMEM, 3'b001, 1'b0, 32'h1234, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1);
      send(7'h7F, 3'b000, 1'b0, 32'h11, 32'h22, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b1, 1);

      // Iterative shifts: 9 -> 3 cycles, 0 and 3 -> 1 cycle, 31 -> 8 cycles.
      send(OPC_OPIMM, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'h409, 32'd0, 32'd0, 1'b1, 32'hFFC00000, 1'b0, 1'b0, 3);
      send(OPC_OPIMM, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'h400, 32'd0, 32'd0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1);
      send(OPC_OP, 3'b001, 1'b0, 32'h00000011, 32'd3, 32'd0, 32'd0, 32'd0, 1'b1, 32'h00000088, 1'b0, 1'b0, 1);
      send(OPC_OP, 3'b101, 1'b0, 32'h80000000, 32'd31, 32'd0, 32'd0, 32'd0, 1'b1, 32'h00000001, 1'b0, 1'b0, 8);

      // Randomised OP / OP-IMM against the reference model.
      for (int k = 0; k < 24; k++) begin
         op  = ($urandom_range(0, 1) != 0) ? OPC_OP : OPC_OPIMM;
         fn  = 3'($urandom_range(0, 7));
         f7  = (fn == 3'd0 || fn == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
         s1  = $urandom;
         s2  = $urandom;
         imm = $urandom;
         b   = (op == OPC_OP) ? s2 : imm;
         lat = (fn == 3'd1 || fn == 3'd5) && (b[4:0] != 5'd0) ? (int'(b[4:0]) + 3) / 4 : 1;
         send(op, fn, f7, s1, s2, imm, 32'd0, 32'd0, 1'b1, ref_alu(op, fn, f7, s1, s2, imm), 1'b0, 1'b0, lat);
      end

      // Backpressure: JAL result held for 5 cycles, then back-to-back ADDI.
      send(OPC_JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'h80000000, 32'd0, 1'b0, 32'h80000004, 1'b0, 1'b0, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk("hold_valid", 64'(o_valid), 64'd1);
         chk("hold_result", 64'(o_result), 64'h80000004);
         chk("hold_ready", 64'(o_ready), 64'd0);
      end
      send(OPC_OPIMM, 3'b000, 1'b0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 1'b1, 32'd2, 1'b0, 1'b0, 1);
      @(negedge clock);
      chk("drain_to_idle", 64'(o_valid), 64'd0);

      // Reset in the middle of a long shift aborts it.
      @(posedge clock); #1;
      drive(OPC_OP, 3'b001, 1'b0, 32'd1, 32'd31, 32'd0, 32'd0, 32'd0, 1'b0);
      wait_accept(ok);
      @(posedge clock); #1;
      i_valid = 1'b0;
      @(negedge clock);
      chk("in_shift_ready", 64'(o_ready), 64'd0);
      chk("in_shift_valid", 64'(o_valid), 64'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("abort_valid", 64'(o_valid), 64'd0);
      chk("abort_idle", 64'(o_ready), 64'd1);
      chk("abort_result", 64'(o_result), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      i_ready = 1'b1;

      // One more op after the abort to show the stage recovers.
      send(OPC_OP, 3'b100, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0, 32'd0, 1'b1, 32'hFF00FF00, 1'b0, 1'b0, 1);

      for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clock);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
